// File: rtl/tdm_demux16.sv
// -----------------------------------------------------------------------------
// tdm_demux16
// Receive-side 1-to-16 time-division demultiplexer. Collects one serial bit per
// enabled cycle into a 16-slot frame that starts at a frame-sync marker, and
// presents each complete frame as a 16-bit word with a one-cycle valid strobe.
// Framing errors (missing or early marker) raise a one-cycle err pulse.
//
// Ports:
//   Clock   in   1   rising-edge clock
//   Reset   in   1   asynchronous, active-high reset
//   en      in   1   bit strobe; d/sync sampled only when en=1
//   d       in   1   serial data bit for the current slot
//   sync    in   1   frame marker, accompanies the slot-0 bit
//   W       out  16  last complete word, W[i] = bit received in slot i
//   valid   out  1   one-cycle pulse when W has just been updated
//   S       out  4   slot index the next enabled bit will occupy
//   locked  out  1   high while frame-locked
//   err     out  1   one-cycle pulse on a framing error
// -----------------------------------------------------------------------------
module tdm_demux16 (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        en,
   input  logic        d,
   input  logic        sync,
   output logic [15:0] W,
   output logic        valid,
   output logic [3:0]  S,
   output logic        locked,
   output logic        err
);

   typedef enum logic [0:0] {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t      r_state;
   // Slot 15 goes straight into the output word, so only slots 0..14 are held.
   logic [14:0] r_shadow;
   logic [15:0] r_w;
   logic        r_valid;
   logic [3:0]  r_s;
   logic        r_locked;
   logic        r_err;

   assign W      = r_w;
   assign valid  = r_valid;
   assign S      = r_s;
   assign locked = r_locked;
   assign err    = r_err;

   // Framing FSM: slot counter, shadow capture, word output and status pulses.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state  <= ST_HUNT;
         r_shadow <= 15'd0;
         r_w      <= 16'd0;
         r_valid  <= 1'b0;
         r_s      <= 4'd0;
         r_locked <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         // valid and err are pulses; they drop on every cycle unless re-raised.
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         if (en) begin
            case (r_state)
               ST_HUNT: begin
                  if (sync) begin
                     r_shadow[0] <= d;
                     r_s         <= 4'd1;
                     r_state     <= ST_LOCKED;
                     r_locked    <= 1'b1;
                  end else begin
                     r_s <= 4'd0;
                  end
               end
               ST_LOCKED: begin
                  if (sync) begin
                     // Marker anywhere but slot 0 abandons the partial frame
                     // and restarts it with this bit as slot 0.
                     if (r_s != 4'd0) begin
                        r_err <= 1'b1;
                     end else begin
                        r_err <= 1'b0;
                     end
                     r_shadow[0] <= d;
                     r_s         <= 4'd1;
                  end else if (r_s == 4'd0) begin
                     // Missing marker: lose lock and discard the bit.
                     r_err    <= 1'b1;
                     r_state  <= ST_HUNT;
                     r_locked <= 1'b0;
                     r_s      <= 4'd0;
                  end else if (r_s == 4'd15) begin
                     r_w     <= {d, r_shadow};
                     r_valid <= 1'b1;
                     r_s     <= 4'd0;
                  end else begin
                     r_shadow[r_s] <= d;
                     r_s           <= r_s + 4'd1;
                  end
               end
               default: begin
                  r_state  <= ST_HUNT;
                  r_s      <= 4'd0;
                  r_locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux16.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux16
// Directed self-checking bench for tdm_demux16. Drives inputs on the falling
// edge and samples outputs 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_tdm_demux16;

   logic        Clock;
   logic        Reset;
   logic        en;
   logic        d;
   logic        sync;
   logic [15:0] W;
   logic        valid;
   logic [3:0]  S;
   logic        locked;
   logic        err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int vcount = 0;
   int ecount = 0;
   int vprev  = 0;
   int vlast  = 0;

   tdm_demux16 dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .en     (en),
      .d      (d),
      .sync   (sync),
      .W      (W),
      .valid  (valid),
      .S      (S),
      .locked (locked),
      .err    (err)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive on the falling edge, sample 1 ns after the rising edge.
   task automatic tick(input logic e, input logic b, input logic s);
      @(negedge Clock);
      en = e; d = b; sync = s;
      @(posedge Clock);
      #1;
      cyc++;
      if (valid === 1'b1) begin
         vcount++;
         vprev = vlast;
         vlast = cyc;
      end
      if (err === 1'b1) ecount++;
   endtask

   // Send a frame LSB first; mask[i]=1 inserts an en=0 cycle before bit i.
   task automatic send_word(input logic [15:0] w, input logic [15:0] mask);
      for (int i = 0; i < 16; i++) begin
         if (mask[i]) tick(1'b0, 1'b0, 1'b0);
         tick(1'b1, w[i], (i == 0));
      end
   endtask

   initial begin
      logic [15:0] pat;
      en = 1'b0; d = 1'b0; sync = 1'b0;
      Reset = 1'b1;
      #2;
      chk("rst_W", W, 16'h0000);
      chk("rst_valid", {15'd0, valid}, 16'd0);
      chk("rst_S", {12'd0, S}, 16'd0);
      chk("rst_locked", {15'd0, locked}, 16'd0);
      chk("rst_err", {15'd0, err}, 16'd0);
      @(negedge Clock);
      Reset = 1'b0;

      // Single frame A5C3.
      tick(1'b1, 1'b1, 1'b1);
      chk("single_S_after_slot0", {12'd0, S}, 16'd1);
      chk("single_locked_early", {15'd0, locked}, 16'd1);
      pat = 16'hA5C3;
      for (int i = 1; i < 16; i++) tick(1'b1, pat[i], 1'b0);
      chk("single_W", W, 16'hA5C3);
      chk("single_valid", {15'd0, valid}, 16'd1);
      chk("single_S", {12'd0, S}, 16'd0);
      chk("single_locked", {15'd0, locked}, 16'd1);
      tick(1'b0, 1'b0, 1'b0);
      chk("single_valid_drop", {15'd0, valid}, 16'd0);
      chk("single_W_hold", W, 16'hA5C3);

      // Streaming with five stall cycles inside the second frame.
      vcount = 0; ecount = 0;
      send_word(16'h1234, 16'h0000);
      chk("stream_W1", W, 16'h1234);
      send_word(16'hFFFE, 16'b0000_1001_0010_0101);
      chk("stream_W2", W, 16'hFFFE);
      chk("stream_vcount", vcount[15:0], 16'd2);
      chk("stream_interval", 16'(vlast - vprev), 16'd21);
      chk("stream_no_err", ecount[15:0], 16'd0);
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
      chk("stall_S_hold", {12'd0, S}, 16'd1);
      // Finish this frame so slot 0 is next.
      for (int i = 1; i < 16; i++) tick(1'b1, 1'b0, 1'b0);
      chk("filler_W", W, 16'h0000);

      // Missing marker.
      send_word(16'h00FF, 16'h0000);
      chk("miss_W_good", W, 16'h00FF);
      tick(1'b1, 1'b1, 1'b0);
      chk("miss_err", {15'd0, err}, 16'd1);
      chk("miss_locked", {15'd0, locked}, 16'd0);
      chk("miss_W_hold", W, 16'h00FF);
      chk("miss_S", {12'd0, S}, 16'd0);
      tick(1'b0, 1'b0, 1'b0);
      chk("miss_err_drop", {15'd0, err}, 16'd0);
      send_word(16'h8001, 16'h0000);
      chk("miss_W_new", W, 16'h8001);
      chk("miss_valid_new", {15'd0, valid}, 16'd1);

      // Early marker at slot 7; that bit becomes slot 0 of 7E7E.
      tick(1'b1, 1'b1, 1'b1);
      for (int i = 1; i < 7; i++) tick(1'b1, 1'b1, 1'b0);
      pat = 16'h7E7E;
      tick(1'b1, pat[0], 1'b1);
      chk("early_err", {15'd0, err}, 16'd1);
      chk("early_valid", {15'd0, valid}, 16'd0);
      chk("early_S", {12'd0, S}, 16'd1);
      chk("early_locked", {15'd0, locked}, 16'd1);
      chk("early_W_hold", W, 16'h8001);
      for (int i = 1; i < 16; i++) tick(1'b1, pat[i], 1'b0);
      chk("early_W", W, 16'h7E7E);
      chk("early_valid_new", {15'd0, valid}, 16'd1);
      chk("early_err_drop", {15'd0, err}, 16'd0);

      // Asynchronous reset mid-stream after loading BEEF.
      send_word(16'hBEEF, 16'h0000);
      chk("pre_rst_W", W, 16'hBEEF);
      tick(1'b1, 1'b1, 1'b1);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      #2;
      Reset = 1'b1;
      #1;
      chk("async_rst_W", W, 16'h0000);
      chk("async_rst_valid", {15'd0, valid}, 16'd0);
      chk("async_rst_err", {15'd0, err}, 16'd0);
      chk("async_rst_S", {12'd0, S}, 16'd0);
      chk("async_rst_locked", {15'd0, locked}, 16'd0);
      @(negedge Clock);
      Reset = 1'b0;

      // Hunt filtering: 40 unmarked bits from reset.
      vcount = 0; ecount = 0;
      for (int i = 0; i < 40; i++) tick(1'b1, 1'($urandom_range(1, 0)), 1'b0);
      chk("hunt_S", {12'd0, S}, 16'd0);
      chk("hunt_locked", {15'd0, locked}, 16'd0);
      chk("hunt_vcount", vcount[15:0], 16'd0);
      chk("hunt_ecount", ecount[15:0], 16'd0);

      // Marker on slot 15: early-marker rule, no valid.
      tick(1'b1, 1'b1, 1'b1);
      for (int i = 1; i < 15; i++) tick(1'b1, 1'b1, 1'b0);
      chk("s15_S_before", {12'd0, S}, 16'd15);
      tick(1'b1, 1'b1, 1'b1);
      chk("s15_err", {15'd0, err}, 16'd1);
      chk("s15_valid", {15'd0, valid}, 16'd0);
      chk("s15_W_hold", W, 16'h0000);
      chk("s15_S", {12'd0, S}, 16'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
